// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures as short, double or long press; events are registered one edge after the deciding sample.
// No backpressure: pulses are single-cycle and must be consumed when seen; evt_cnt wraps modulo 256.
module key_event_decoder #(
  parameter int LONG_CNT = 48,
  parameter int GAP_CNT  = 32,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       short_press,
  output logic       double_press,
  output logic       long_press,
  output logic       hold,
  output logic [7:0] evt_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             hold_q, hold_d;
  logic [7:0]       evt_q, evt_d;

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_in) state_d = PRESS1;
      end
      PRESS1: begin
        // A release sampled on the threshold edge still counts as a short press.
        if (!key_in) begin
          state_d = WAIT2;
        end else if (timer_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (key_in) begin
          state_d = PRESS2;
        end else if (timer_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (!key_in) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end
      end
      LONG: begin
        if (!key_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Saturate so idle or long-held states never alias back onto a threshold.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + CNT_W'(1);
    end else begin
      timer_d = timer_q;
    end

    hold_d = (state_d == LONG);
    evt_d  = (short_d | double_d | long_d) ? evt_q + 8'd1 : evt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      hold_q   <= 1'b0;
      evt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      hold_q   <= hold_d;
      evt_q    <= evt_d;
    end
  end

  assign short_press  = short_q;
  assign double_press = double_q;
  assign long_press   = long_q;
  assign hold         = hold_q;
  assign evt_cnt      = evt_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed gesture sequence with a scoreboard of expected (event kind, setting edge) pairs.
module tb_key_event_decoder;

  localparam int LONG_CNT = 48;
  localparam int GAP_CNT  = 32;

  localparam logic [31:0] K_SHORT  = 32'd0;
  localparam logic [31:0] K_DOUBLE = 32'd1;
  localparam logic [31:0] K_LONG   = 32'd2;

  typedef struct {
    logic [31:0] kind;
    int          edge_n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b0;
  logic       short_press, double_press, long_press, hold;
  logic [7:0] evt_cnt;

  int         cyc = 0;
  int         total = 0;
  int         pass_cnt = 0;
  int         fail_cnt = 0;
  logic [7:0] exp_evt = 8'd0;
  exp_t       sb_q[$];
  logic       prev_any = 1'b0;

  key_event_decoder #(.LONG_CNT(LONG_CNT), .GAP_CNT(GAP_CNT), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .short_press  (short_press),
    .double_press (double_press),
    .long_press   (long_press),
    .hold         (hold),
    .evt_cnt      (evt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input logic val, input int n);
    key_in = val;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] kind, input int edge_n);
    exp_t e;
    e.kind   = kind;
    e.edge_n = edge_n;
    sb_q.push_back(e);
    exp_evt = exp_evt + 8'd1;
  endtask

  // Pops one expectation for every pulse the DUT shows.
  always @(negedge clk) begin
    logic        any;
    logic [31:0] kind;
    exp_t        e;
    any = short_press | double_press | long_press;
    if (!rst && any) begin
      chk("one_hot_pulse", 32'($countones({short_press, double_press, long_press})), 32'd1);
      chk("pulse_width", {31'd0, prev_any}, 32'd0);
      kind = long_press ? K_LONG : (double_press ? K_DOUBLE : K_SHORT);
      if (long_press) chk("hold_with_long", {31'd0, hold}, 32'd1);
      if (sb_q.size() == 0) begin
        chk("unexpected_event", kind, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_edge", 32'(cyc), 32'(e.edge_n));
      end
    end
    prev_any = rst ? 1'b0 : any;
  end

  initial begin
    int r;
    int t;

    #1;
    chk("rst_short", {31'd0, short_press}, 32'd0);
    chk("rst_double", {31'd0, double_press}, 32'd0);
    chk("rst_long", {31'd0, long_press}, 32'd0);
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_evt", {24'd0, evt_cnt}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 4);

    // Short press
    drive(1'b1, 10);
    r = cyc + 1;
    push(K_SHORT, r + GAP_CNT);
    drive(1'b0, 40);
    chk("short_evt", {24'd0, evt_cnt}, {24'd0, exp_evt});

    // Double press
    drive(1'b1, 5);
    drive(1'b0, 10);
    drive(1'b1, 5);
    r = cyc + 1;
    push(K_DOUBLE, r);
    drive(1'b0, 40);
    chk("double_evt", {24'd0, evt_cnt}, {24'd0, exp_evt});

    // Long press with hold timing
    t = cyc + 1;
    push(K_LONG, t + LONG_CNT);
    drive(1'b1, LONG_CNT);
    chk("hold_before_long", {31'd0, hold}, 32'd0);
    drive(1'b1, 1);
    chk("long_level", {31'd0, long_press}, 32'd1);
    chk("hold_at_long", {31'd0, hold}, 32'd1);
    drive(1'b1, 100 - LONG_CNT - 1);
    chk("hold_late", {31'd0, hold}, 32'd1);
    drive(1'b0, 1);
    chk("hold_after_release", {31'd0, hold}, 32'd0);
    drive(1'b0, 40);
    chk("long_evt", {24'd0, evt_cnt}, {24'd0, exp_evt});

    // Release on the long-threshold edge takes the short path
    drive(1'b1, LONG_CNT);
    r = cyc + 1;
    push(K_SHORT, r + GAP_CNT);
    drive(1'b0, 40);
    chk("bound_long_evt", {24'd0, evt_cnt}, {24'd0, exp_evt});

    // Second press on the gap-timeout edge still forms a double press
    drive(1'b1, 5);
    drive(1'b0, GAP_CNT);
    drive(1'b1, 3);
    r = cyc + 1;
    push(K_DOUBLE, r);
    drive(1'b0, 40);
    chk("bound_gap_evt", {24'd0, evt_cnt}, {24'd0, exp_evt});

    // A long second press never times out into long_press
    drive(1'b1, 5);
    drive(1'b0, 5);
    drive(1'b1, 80);
    r = cyc + 1;
    push(K_DOUBLE, r);
    drive(1'b0, 40);

    // Reset while in PRESS2
    drive(1'b1, 5);
    drive(1'b0, 5);
    drive(1'b1, 5);
    rst = 1'b1;
    #1;
    chk("rstp2_evt", {24'd0, evt_cnt}, 32'd0);
    chk("rstp2_pulses", {29'd0, short_press, double_press, long_press}, 32'd0);
    exp_evt = 8'd0;
    key_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 50);
    chk("rstp2_after", {24'd0, evt_cnt}, 32'd0);

    // Reset while in LONG, key held through reset release
    t = cyc + 1;
    push(K_LONG, t + LONG_CNT);
    drive(1'b1, 60);
    chk("rstl_hold_pre", {31'd0, hold}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstl_hold", {31'd0, hold}, 32'd0);
    chk("rstl_evt", {24'd0, evt_cnt}, 32'd0);
    exp_evt = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    t = cyc + 1;
    push(K_LONG, t + LONG_CNT);
    drive(1'b1, 60);
    drive(1'b0, 40);
    chk("rstl_relong_evt", {24'd0, evt_cnt}, {24'd0, exp_evt});

    // Counter wrap from a clean reset
    rst = 1'b1;
    exp_evt = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 2);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 3);
      r = cyc + 1;
      push(K_SHORT, r + GAP_CNT);
      drive(1'b0, GAP_CNT + 2);
      if (i == 254) chk("wrap_255", {24'd0, evt_cnt}, 32'd255);
    end
    chk("wrap_zero", {24'd0, evt_cnt}, 32'd0);
    chk("wrap_model", {24'd0, evt_cnt}, {24'd0, exp_evt});

    drive(1'b0, 80);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
